mm_controller: RTL and testbench
================================

# mm_controller

Sequencing controller for the matrix-multiply datapath. On `start` it latches the three dimensions, then walks every output element (i, j), issuing A/B buffer read addresses for the inner index k, steering the accumulator (`init0reg`, `ldreg`) and pulsing `res_we` with the result address. It sits between the host command interface and the datapath, replacing hand-driven control lines.

## Interface
- `N`, default 8: data/dimension width, matching the datapath `n`.
- `M`, default 6: buffer and result address width, matching the datapath `m`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle command pulse; sampled only in IDLE.
- `dim0`, `dim1`, `dim2`  in  N each  latched datapath dimensions: rows of A, inner size, columns of B.
- `loaddim`  out  1  load pulse for the datapath dimension registers.
- `aadr`, `badr`  out  M each  A/B buffer read addresses.
- `abufread`, `bbufread`  out  1 each  buffer read enables.
- `init0reg`  out  1  clear the accumulator.
- `ldreg`  out  1  load accumulator with product+acc.
- `res_we`  out  1  result RAM write enable.
- `resadr`  out  M  result RAM write address.
- `busy`  out  1  high from the cycle after accepted `start` through DONE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, INIT, MAC, DRAIN, WRITE, DONE.
- IDLE: all outputs 0. `start` moves to LOAD; `start` in any other state is ignored.
- LOAD: `loaddim`=1 for one cycle; the datapath dims become valid at the next edge. Clears i, j, k and the bases.
- Next state after LOAD: if any of dim0, dim1, dim2 is 0, go to DONE with no reads or writes; otherwise go to INIT.
- INIT: `init0reg`=1 for one cycle, k←0.
- MAC: one cycle per k in 0..dim1-1, with `abufread`=`bbufread`=1.
  - `aadr` = i·dim1 + k; `badr` = k·dim2 + j.
  - Addresses come from incrementing counters (`abase`+=dim1 per row, `bptr`+=dim2 per k); no multipliers.
  - All address arithmetic is modulo 2^M (silent wrap).
  - Leave to DRAIN after k = dim1-1.
- DRAIN: one cycle; no reads. This is the last `ldreg` cycle.
- `ldreg` is the read enable delayed by one register. It is high from the second MAC cycle through DRAIN, dim1 cycles in total.
- WRITE: `res_we`=1, `resadr` = i·dim2 + j (running counter, +1 per element, mod 2^M).
  - Advance j. On j = dim2-1, set j←0 and i++.
  - After i = dim0-1 and j = dim2-1, go to DONE; else go to INIT.
- DONE: `done`=1 for one cycle, then IDLE.
- Address/enable outputs are Moore-decoded from state and counter registers. `ldreg` is a registered output.

## Timing
- Reset values: every output 0, state IDLE, all counters 0.
- Reset asserted mid-operation aborts immediately. No further `res_we` is issued, and the partial RAM contents are not cleared.
- `start` is accepted at edge 0:
  - LOAD is cycle 1.
  - Each element takes dim1+3 cycles (INIT, dim1×MAC, DRAIN, WRITE).
  - DONE is cycle 2 + dim0·dim2·(dim1+3).
  - Zero-dim case: DONE is cycle 2.
- Buffers deliver data one cycle after the address and read enable. The accumulator captures on the `ldreg` edge, so `result` is valid in WRITE.
- `busy`=1 in every state except IDLE. The host must not drive `abufwrite`/`bbufwrite` while `busy`.

## Structure
- Shared package `mm_pkg`: state enum `mm_state_t` and the state encoding constants.
- Single flat module; no natural sub-module. Counters are i, j, k, `abase`, `bptr`, `resadr`, plus the `ldreg` delay flop.

## Test plan
- 2×2×2 with A=[1 2;3 4], B=[5 6;7 8]:
  - RAM[0..3] = 19, 22, 43, 50.
  - Exactly 4 `res_we` pulses.
  - `done` at cycle 22.
- 1×3×1 with A=[1 2 3], B=[4 5 6]ᵀ:
  - `aadr` sequence 0, 1, 2; `badr` sequence 0, 1, 2.
  - 3 `ldreg` cycles; RAM[0]=32; `done` at cycle 8.
- dim1=0:
  - `done` at cycle 2.
  - No `abufread`, `ldreg` or `res_we` ever asserted.
- `rst` pulsed during the second MAC cycle of a 2×2×2 job:
  - All outputs 0 within the reset cycle, state IDLE.
  - A subsequent `start` reruns and produces correct results.
- `start` held high / re-pulsed while `busy`: no restart; sequence and `done` timing identical to the single-pulse run.
- M=4, dims 3×3×3: `badr` never exceeds 15, `resadr` ends at 8, `done` pulses once.

Source files
------------

// File: rtl/mm_pkg.sv
// mm_pkg: state encoding shared by the matrix-multiply controller and its users.
package mm_pkg;
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      INIT  = 3'd2,
      MAC   = 3'd3,
      DRAIN = 3'd4,
      WRITE = 3'd5,
      DONE  = 3'd6
   } mm_state_t;
endpackage

// File: rtl/mm_controller.sv
// mm_controller: walks every output element of C = A*B, driving buffer reads,
// accumulator control and result writes for the matrix-multiply datapath.
module mm_controller
   import mm_pkg::*;
#(
   parameter int N = 8,
   parameter int M = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dim0,
   input  logic [N-1:0] dim1,
   input  logic [N-1:0] dim2,
   output logic         loaddim,
   output logic [M-1:0] aadr,
   output logic [M-1:0] badr,
   output logic         abufread,
   output logic         bbufread,
   output logic         init0reg,
   output logic         ldreg,
   output logic         res_we,
   output logic [M-1:0] resadr,
   output logic         busy,
   output logic         done
);
   mm_state_t state, state_n;
   logic [N-1:0] d0, d1, d2, i, j, k;
   logic [M-1:0] abase, bptr, radr;
   logic last_i, last_j, last_k, zero;

   assign last_i = i == d0 - N'(1);
   assign last_j = j == d2 - N'(1);
   assign last_k = k == d1 - N'(1);
   assign zero   = d0 == '0 || d1 == '0 || d2 == '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         {d0, d1, d2, i, j, k} <= '0;
         {abase, bptr, radr} <= '0;
         ldreg <= 1'b0;
      end else begin
         state <= state_n;
         ldreg <= state == MAC;
         case (state)
            IDLE: if (start) {d0, d1, d2} <= {dim0, dim1, dim2};
            LOAD: begin
               {i, j, k} <= '0;
               {abase, bptr, radr} <= '0;
            end
            INIT: begin
               k    <= '0;
               bptr <= '0;
            end
            MAC: begin
               k    <= k + N'(1);
               bptr <= bptr + M'(d2);
            end
            WRITE: begin
               radr <= radr + M'(1);
               // row wrap: column restarts and the A row base steps by the inner size
               if (last_j) begin
                  j     <= '0;
                  i     <= i + N'(1);
                  abase <= abase + M'(d1);
               end else
                  j <= j + N'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_n  = state;
      loaddim  = state == LOAD;
      abufread = state == MAC;
      bbufread = state == MAC;
      init0reg = state == INIT;
      res_we   = state == WRITE;
      busy     = state != IDLE;
      done     = state == DONE;
      aadr     = abufread ? abase + M'(k) : '0;
      badr     = abufread ? bptr + M'(j) : '0;
      resadr   = res_we ? radr : '0;
      case (state)
         IDLE:    state_n = start ? LOAD : IDLE;
         LOAD:    state_n = zero ? DONE : INIT;
         INIT:    state_n = MAC;
         MAC:     state_n = last_k ? DRAIN : MAC;
         DRAIN:   state_n = WRITE;
         WRITE:   state_n = (last_i && last_j) ? DONE : INIT;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mm_controller.sv
// tb_mm_controller: scoreboard bench with a behavioural buffer/accumulator model.
module tb_mm_controller;
   localparam int N = 8;
   localparam int M = 4;
   localparam int W = 1 << M;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [N-1:0] dim0 = '0, dim1 = '0, dim2 = '0;
   logic loaddim, abufread, bbufread, init0reg, ldreg, res_we, busy, done;
   logic [M-1:0] aadr, badr, resadr;

   always #5 clk = ~clk;

   mm_controller #(.N(N), .M(M)) dut (
      .clk(clk), .rst(rst), .start(start),
      .dim0(dim0), .dim1(dim1), .dim2(dim2),
      .loaddim(loaddim), .aadr(aadr), .badr(badr),
      .abufread(abufread), .bbufread(bbufread),
      .init0reg(init0reg), .ldreg(ldreg), .res_we(res_we),
      .resadr(resadr), .busy(busy), .done(done)
   );

   typedef struct {int a; int b;} pair_t;
   pair_t rd_q[$], wr_q[$], dn_q[$];
   int abuf[W], bbuf[W];
   int hand[4];
   bit use_hand;
   int ad = 0, bd = 0, acc = 0;
   int cyc = 0, start_at = 0;
   int total = 0, bad = 0, ld_cnt = 0;

   // datapath model: buffers answer one cycle after the read, accumulator captures on ldreg
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (abufread) ad <= abuf[aadr];
      if (bbufread) bd <= bbuf[badr];
      if (init0reg) acc <= 0;
      else if (ldreg) acc <= acc + ad * bd;
   end

   task automatic chk(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d at cycle %0d", name, got, want, cyc - start_at);
      end
   endtask

   always @(negedge clk) begin
      pair_t e;
      if (rst) begin
         ld_cnt = 0;
         chk("reset_outputs", int'({loaddim, abufread, bbufread, init0reg, ldreg, res_we,
                                    busy, done, aadr, badr, resadr}), 0);
      end else begin
         if (ldreg) ld_cnt++;
         if (abufread || bbufread) begin
            chk("rd_en", int'({abufread, bbufread}), 3);
            if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
            else begin
               e = rd_q.pop_front();
               chk("aadr", int'(aadr), e.a);
               chk("badr", int'(badr), e.b);
            end
         end
         if (res_we) begin
            if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               e = wr_q.pop_front();
               chk("resadr", int'(resadr), e.a);
               chk("result", acc, e.b);
            end
         end
         if (done) begin
            if (dn_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               e = dn_q.pop_front();
               chk("done_cycle", cyc - start_at, e.a);
               chk("ldreg_count", ld_cnt, e.b);
               chk("busy_at_done", int'(busy), 1);
               chk("pending_reads", rd_q.size(), 0);
               chk("pending_writes", wr_q.size(), 0);
            end
            ld_cnt = 0;
         end
      end
   end

   task automatic expect_job(input int d0, input int d1, input int d2);
      pair_t p;
      int s;
      bit ok = d0 != 0 && d1 != 0 && d2 != 0;
      if (ok)
         for (int i = 0; i < d0; i++)
            for (int j = 0; j < d2; j++) begin
               s = 0;
               for (int k = 0; k < d1; k++) begin
                  p.a = (i * d1 + k) % W;
                  p.b = (k * d2 + j) % W;
                  s += abuf[p.a] * bbuf[p.b];
                  rd_q.push_back(p);
               end
               p.a = (i * d2 + j) % W;
               p.b = use_hand ? hand[i * d2 + j] : s;
               wr_q.push_back(p);
            end
      p.a = ok ? 2 + d0 * d2 * (d1 + 3) : 2;
      p.b = d0 * d1 * d2;
      dn_q.push_back(p);
   endtask

   task automatic run_job(input int d0, input int d1, input int d2, input bit hold);
      int t = 0;
      expect_job(d0, d1, d2);
      @(negedge clk);
      dim0 = N'(d0); dim1 = N'(d1); dim2 = N'(d2);
      start = 1'b1;
      start_at = cyc;
      @(negedge clk);
      dim0 = 8'd9; dim1 = 8'd9; dim2 = 8'd9;
      if (hold) begin
         repeat (11) @(negedge clk);
         start = 1'b0;
         repeat (3) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
      end
      start = 1'b0;
      while (!done && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (!done) begin
         $display("FAIL done_timeout: got=none want=done after %0d cycles", t);
         $fatal(1);
      end
      @(negedge clk);
   endtask

   task automatic load_2x2;
      abuf[0] = 1; abuf[1] = 2; abuf[2] = 3; abuf[3] = 4;
      bbuf[0] = 5; bbuf[1] = 6; bbuf[2] = 7; bbuf[3] = 8;
      hand = '{19, 22, 43, 50};
      use_hand = 1'b1;
   endtask

   initial begin
      pair_t p;
      for (int x = 0; x < W; x++) begin
         abuf[x] = 0;
         bbuf[x] = 0;
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      load_2x2();
      run_job(2, 2, 2, 1'b0);
      abuf[0] = 1; abuf[1] = 2; abuf[2] = 3;
      bbuf[0] = 4; bbuf[1] = 5; bbuf[2] = 6;
      hand[0] = 32;
      run_job(1, 3, 1, 1'b0);
      use_hand = 1'b0;
      run_job(2, 0, 2, 1'b0);
      load_2x2();
      // abort in the second MAC cycle: only the first MAC read is ever seen unreset
      p.a = 0; p.b = 0;
      rd_q.push_back(p);
      @(negedge clk);
      dim0 = 8'd2; dim1 = 8'd2; dim2 = 8'd2;
      start = 1'b1;
      start_at = cyc;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("abort_reads_consumed", rd_q.size(), 0);
      run_job(2, 2, 2, 1'b0);
      run_job(2, 2, 2, 1'b1);
      use_hand = 1'b0;
      for (int x = 0; x < W; x++) begin
         abuf[x] = x + 1;
         bbuf[x] = x % 3 + 1;
      end
      run_job(3, 3, 3, 1'b0);
      run_job(4, 5, 4, 1'b0);
      repeat (3) @(negedge clk);
      chk("final_pending_done", dn_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
